// File: rtl/sik_pkg.sv
// SIK ISA definitions shared by the core and its stack: opcodes, ALU functs,
// FSM states and fault codes.
package sik_pkg;

  typedef enum logic [3:0] {
    OP_PUSH  = 4'h0,
    OP_PRE   = 4'h1,
    OP_JUMP  = 4'h2,
    OP_JUMPT = 4'h3,
    OP_JUMPF = 4'h4,
    OP_CALL  = 4'h5,
    OP_RET   = 4'h6,
    OP_ILL   = 4'h7,
    OP_DUP   = 4'h8,
    OP_GET   = 4'h9,
    OP_PUT   = 4'hA,
    OP_POP   = 4'hB,
    OP_LOAD  = 4'hC,
    OP_STORE = 4'hD,
    OP_SYS   = 4'hE,
    OP_ALU   = 4'hF
  } opcode_e;

  // ALU funct field is one-hot in the immediate; any other pattern is illegal
  localparam logic [31:0] FN_ADD  = 32'h01;
  localparam logic [31:0] FN_SUB  = 32'h02;
  localparam logic [31:0] FN_AND  = 32'h04;
  localparam logic [31:0] FN_OR   = 32'h08;
  localparam logic [31:0] FN_XOR  = 32'h10;
  localparam logic [31:0] FN_LT   = 32'h20;
  localparam logic [31:0] FN_TEST = 32'h40;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LT, ALU_TEST, ALU_BAD
  } alu_e;

  typedef enum logic [1:0] {
    S_FETCH, S_EXEC, S_MEM, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_OVER    = 2'd1,
    FLT_UNDER   = 2'd2,
    FLT_ILLEGAL = 2'd3
  } fault_e;

  function automatic alu_e decode_funct(input logic [31:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_LT:   return ALU_LT;
      FN_TEST: return ALU_TEST;
      default: return ALU_BAD;
    endcase
  endfunction

endpackage

// File: rtl/sik_stack.sv
// SIK data stack: 2^SP_BITS x WIDTH register file, two async read ports,
// one synchronous write port, contents not reset.
module sik_stack
  import sik_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SP_BITS = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [SP_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [SP_BITS-1:0] raddr_a,
  output logic [WIDTH-1:0]   rdata_a,
  input  logic [SP_BITS-1:0] raddr_b,
  output logic [WIDTH-1:0]   rdata_b
);

  logic [WIDTH-1:0] mem [2**SP_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/sik_core.sv
// SIK multi-cycle stack-machine core with external req/ack memory.
// Optional stack overflow/underflow trapping: define SIK_STACK_CHECK_EN.
module sik_core
  import sik_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SP_BITS  = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             halt,
  output logic [1:0]       fault
);

  localparam int unsigned IMMW = WIDTH - 4;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d;
  logic [SP_BITS-1:0] sp_q, sp_d;
  logic               torf_q, torf_d, validpre_q, validpre_d, halt_q, halt_d;
  logic [3:0]         pre_q, pre_d;
  fault_e             fault_q, fault_d, chk;
  logic               req_q, req_d, we_q, we_d;
  logic [WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d;

  opcode_e            op;
  alu_e               alu;
  logic [IMMW-1:0]    imm;
  logic [SP_BITS-1:0] k, rd_b_addr, sp_inc, sp_dec;
  logic [WIDTH-1:0]   tgt, tos, nos, alu_res;
  logic               illegal, ack_v;
  logic               st_we;
  logic [SP_BITS-1:0] st_waddr;
  logic [WIDTH-1:0]   st_wdata;

  sik_stack #(.WIDTH(WIDTH), .SP_BITS(SP_BITS)) u_stack (
    .clk     (clk),
    .we      (st_we),
    .waddr   (st_waddr),
    .wdata   (st_wdata),
    .raddr_a (sp_q),
    .rdata_a (tos),
    .raddr_b (rd_b_addr),
    .rdata_b (nos)
  );

  assign ack_v = mem_ack & req_q;

  always_comb begin : decode
    op        = opcode_e'(ir_q[WIDTH-1 -: 4]);
    imm       = ir_q[IMMW-1:0];
    alu       = decode_funct(32'(imm));
    k         = SP_BITS'(imm);
    tgt       = validpre_q ? {pre_q, imm} : {pc_q[WIDTH-1 -: 4], imm};
    illegal   = (op == OP_ILL) || (op == OP_ALU && alu == ALU_BAD);
    sp_inc    = sp_q + SP_BITS'(1);
    sp_dec    = sp_q - SP_BITS'(1);
    // Second read port serves N (offset 1) except for GET/PUT (offset k)
    rd_b_addr = sp_q - ((op == OP_GET || op == OP_PUT) ? k : SP_BITS'(1));
  end

  always_comb begin : alu_path
    alu_res = '0;
    case (alu)
      ALU_ADD: alu_res = nos + tos;
      ALU_SUB: alu_res = nos - tos;
      ALU_AND: alu_res = nos & tos;
      ALU_OR:  alu_res = nos | tos;
      ALU_XOR: alu_res = nos ^ tos;
      ALU_LT:  alu_res = WIDTH'(nos < tos);
      default: alu_res = '0;
    endcase
  end

  always_comb begin : stack_check
    chk = FLT_NONE;
`ifdef SIK_STACK_CHECK_EN
    if ((op inside {OP_PUSH, OP_CALL, OP_DUP, OP_GET}) && sp_q == '1)
      chk = FLT_OVER;
    else if (((op == OP_ALU && alu != ALU_TEST) || op == OP_STORE) && 32'(sp_q) < 32'd2)
      chk = FLT_UNDER;
    else if (((op inside {OP_RET, OP_LOAD, OP_DUP, OP_PUT}) ||
              (op == OP_ALU && alu == ALU_TEST)) && sp_q == '0)
      chk = FLT_UNDER;
    else if ((op inside {OP_GET, OP_PUT}) && 32'(imm) >= 32'(sp_q))
      chk = FLT_UNDER;
    else if (op == OP_POP && 32'(imm) > 32'(sp_q))
      chk = FLT_UNDER;
`endif
  end

  always_comb begin : next_state
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    ir_d       = ir_q;
    torf_d     = torf_q;
    pre_d      = pre_q;
    validpre_d = validpre_q;
    halt_d     = halt_q;
    fault_d    = fault_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    st_we      = 1'b0;
    st_waddr   = sp_q;
    st_wdata   = tos;

    case (state_q)
      S_FETCH: begin
        req_d  = 1'b1;
        we_d   = 1'b0;
        addr_d = pc_q;
        if (ack_v) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + WIDTH'(1);
          req_d   = 1'b0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (illegal) begin
          halt_d  = 1'b1;
          fault_d = FLT_ILLEGAL;
          state_d = S_HALT;
        end else if (chk != FLT_NONE) begin
          halt_d  = 1'b1;
          fault_d = chk;
          state_d = S_HALT;
        end else begin
          case (op)
            OP_PUSH: begin
              st_we = 1'b1; st_waddr = sp_inc; st_wdata = tgt;
              sp_d = sp_inc; validpre_d = 1'b0;
            end
            OP_PRE: begin
              pre_d = ir_q[3:0]; validpre_d = 1'b1;
            end
            OP_JUMP: begin
              pc_d = tgt; validpre_d = 1'b0;
            end
            OP_JUMPT: begin
              if (torf_q) pc_d = tgt;
              validpre_d = 1'b0;
            end
            OP_JUMPF: begin
              if (!torf_q) pc_d = tgt;
              validpre_d = 1'b0;
            end
            OP_CALL: begin
              st_we = 1'b1; st_waddr = sp_inc; st_wdata = pc_q;
              sp_d = sp_inc; pc_d = tgt; validpre_d = 1'b0;
            end
            OP_RET: begin
              pc_d = tos; sp_d = sp_dec;
            end
            OP_DUP: begin
              st_we = 1'b1; st_waddr = sp_inc; st_wdata = tos; sp_d = sp_inc;
            end
            OP_GET: begin
              st_we = 1'b1; st_waddr = sp_inc; st_wdata = nos; sp_d = sp_inc;
            end
            OP_PUT: begin
              st_we = 1'b1; st_waddr = rd_b_addr; st_wdata = tos;
            end
            OP_POP: sp_d = sp_q - k;
            OP_LOAD: begin
              state_d = S_MEM; req_d = 1'b1; we_d = 1'b0; addr_d = tos;
            end
            OP_STORE: begin
              state_d = S_MEM; req_d = 1'b1; we_d = 1'b1;
              addr_d = nos; wdata_d = tos;
            end
            OP_SYS: begin
              halt_d = 1'b1; fault_d = FLT_NONE; state_d = S_HALT;
            end
            OP_ALU: begin
              sp_d = sp_dec;
              if (alu == ALU_TEST) torf_d = (tos != '0);
              else begin
                st_we = 1'b1; st_waddr = rd_b_addr; st_wdata = alu_res;
              end
            end
            default: ;
          endcase
        end
      end

      S_MEM: begin
        if (ack_v) begin
          state_d = S_FETCH;
          st_we   = 1'b1;
          if (we_q) begin
            st_waddr = rd_b_addr; st_wdata = tos; sp_d = sp_dec;
          end else begin
            st_waddr = sp_q; st_wdata = mem_rdata;
          end
        end
      end

      default: req_d = 1'b0;
    endcase

    // Request for the next fetch is registered on entry so it is up one cycle earlier
    if (state_q != S_FETCH && state_d == S_FETCH) begin
      req_d  = 1'b1;
      we_d   = 1'b0;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= WIDTH'(RESET_PC);
      sp_q       <= '0;
      ir_q       <= '0;
      torf_q     <= 1'b0;
      pre_q      <= '0;
      validpre_q <= 1'b0;
      halt_q     <= 1'b0;
      fault_q    <= FLT_NONE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      ir_q       <= ir_d;
      torf_q     <= torf_d;
      pre_q      <= pre_d;
      validpre_q <= validpre_d;
      halt_q     <= halt_d;
      fault_q    <= fault_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halt      = halt_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_sik_core.sv
// Directed self-checking bench for sik_core with a word memory responder
// whose ack latency is programmable.
module tb_sik_core;

`ifdef SIK_STACK_CHECK_EN
  localparam int SPB = 2;
`else
  localparam int SPB = 8;
`endif

  logic        clk, reset;
  logic        mem_req, mem_we, mem_ack, halt;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  fault;

  sik_core #(.WIDTH(16), .SP_BITS(SPB), .RESET_PC(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halt      (halt),
    .fault     (fault)
  );

  logic [15:0] mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          wcnt = 0;
  int          st_cycles = 0;
  int          st_match = 0;
  logic        prev_req = 1'b0;
  logic        cap_we = 1'b0;
  logic [15:0] cap_addr = '0, cap_wdata = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: decisions at negedge, so the DUT sees stable ack/rdata
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack && cap_we) mem[cap_addr] = cap_wdata;
      if (!mem_req || mem_ack || !prev_req) wcnt = 0;
      else wcnt++;
      prev_req = mem_req;
      if (mem_req && mem_we) begin
        st_cycles++;
        if (mem_addr == 16'h0100 && mem_wdata == 16'hBEEF) st_match++;
      end
      if (mem_req && wcnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        cap_we    = mem_we;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h7000;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    reset = 1'b1;
    while (!halt && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_halted"}, halt, 1);
  endtask

  initial begin
    int n;
    reset = 1'b0;

    // T1: PUSH 5, PUSH 3, SUB, SYS; reset values and SYS timing
    clear_mem();
    mem[0] = 16'h0005; mem[1] = 16'h0003; mem[2] = 16'hF002; mem[3] = 16'hE000;
    ack_delay = 0;
    apply_reset();
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_halt", halt, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", dut.pc_q, 0);
    check("rst_sp", dut.sp_q, 0);
    check("rst_validpre", dut.validpre_q, 0);
    check("rst_torf", dut.torf_q, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t1_first_req", mem_req, 1);
    check("t1_first_addr", mem_addr, 0);
    n = 1;
    while (!halt && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t1_halt_cycle", n, 9);
    check("t1_halt", halt, 1);
    check("t1_fault", fault, 0);
    check("t1_sp", dut.sp_q, 1);
    check("t1_tos", dut.tos, 16'h0002);
    check("t1_req_halted", mem_req, 0);

    // T2: PRE 1, JUMP 0x010 -> 0x1010; JUMP 0x020 -> 0x1020
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h2010; mem[16'h1010] = 16'h2020; mem[16'h1020] = 16'hE000;
    apply_reset();
    run_to_halt("t2", 200);
    check("t2_fault", fault, 0);
    check("t2_pc", dut.pc_q, 16'h1021);
    check("t2_validpre", dut.validpre_q, 0);

    // T3: CALL at 0x0005, DUP, RET back to 0x0006
    clear_mem();
    mem[0] = 16'h2005; mem[5] = 16'h5040; mem[16'h40] = 16'h8000;
    mem[16'h41] = 16'h6000; mem[6] = 16'hE000;
    apply_reset();
    run_to_halt("t3", 200);
    check("t3_fault", fault, 0);
    check("t3_pc", dut.pc_q, 16'h0007);
    check("t3_sp", dut.sp_q, 1);
    check("t3_tos", dut.tos, 16'h0006);

    // T4: STORE 0xBEEF to 0x100 with 3-cycle ack delay
    clear_mem();
    mem[0] = 16'h0100; mem[1] = 16'h100B; mem[2] = 16'h0EEF; mem[3] = 16'hD000; mem[4] = 16'hE000;
    ack_delay = 3;
    apply_reset();
    st_cycles = 0; st_match = 0;
    run_to_halt("t4", 400);
    ack_delay = 0;
    check("t4_fault", fault, 0);
    check("t4_store_cycles", st_cycles, 4);
    check("t4_store_stable", st_match, 4);
    check("t4_mem", mem[16'h0100], 16'hBEEF);
    check("t4_sp", dut.sp_q, 1);
    check("t4_tos", dut.tos, 16'hBEEF);

    // T5: LOAD, AND, OR, XOR, LT (equal operands), TEST, JUMPF taken, JUMPT not taken
    clear_mem();
    mem[16'h200] = 16'h1234;
    mem[0] = 16'h0200; mem[1] = 16'hC000; mem[2] = 16'h00F0; mem[3] = 16'hF004;
    mem[4] = 16'h000F; mem[5] = 16'hF008; mem[6] = 16'h0011; mem[7] = 16'hF010;
    mem[8] = 16'h002E; mem[9] = 16'hF020; mem[10] = 16'hF040; mem[11] = 16'h4020;
    mem[16'h20] = 16'h3030; mem[16'h21] = 16'hE000;
    apply_reset();
    run_to_halt("t5", 300);
    check("t5_fault", fault, 0);
    check("t5_pc", dut.pc_q, 16'h0022);
    check("t5_sp", dut.sp_q, 0);
    check("t5_torf", dut.torf_q, 0);

`ifndef SIK_STACK_CHECK_EN
    // T6: GET 2, PUT 2, POP 1, GET 1, ADD -> C + A
    clear_mem();
    mem[0] = 16'h000A; mem[1] = 16'h000B; mem[2] = 16'h000C; mem[3] = 16'h9002;
    mem[4] = 16'hA002; mem[5] = 16'hB001; mem[6] = 16'h9001; mem[7] = 16'hF001; mem[8] = 16'hE000;
    apply_reset();
    run_to_halt("t6", 300);
    check("t6_fault", fault, 0);
    check("t6_sp", dut.sp_q, 3);
    check("t6_tos", dut.tos, 16'h0016);
`endif

    // T7a: non-one-hot funct at sp=0 -> illegal wins
    clear_mem();
    mem[0] = 16'hF003;
    apply_reset();
    run_to_halt("t7a", 100);
    check("t7a_fault", fault, 3);
    check("t7a_sp", dut.sp_q, 0);

    // T7b: opcode 7 after a push
    clear_mem();
    mem[0] = 16'h0001;
    apply_reset();
    run_to_halt("t7b", 100);
    check("t7b_fault", fault, 3);
    check("t7b_sp", dut.sp_q, 1);
    check("t7b_pc", dut.pc_q, 16'h0002);

`ifdef SIK_STACK_CHECK_EN
    // Overflow on the fourth push with a 4-slot stack
    clear_mem();
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
    apply_reset();
    run_to_halt("ovf", 100);
    check("ovf_fault", fault, 1);
    check("ovf_sp", dut.sp_q, 3);
    check("ovf_tos", dut.tos, 16'h0003);
    check("ovf_pc", dut.pc_q, 16'h0004);

    // Underflow: ADD with one entry
    clear_mem();
    mem[0] = 16'h0001; mem[1] = 16'hF001;
    apply_reset();
    run_to_halt("unf", 100);
    check("unf_fault", fault, 2);
    check("unf_sp", dut.sp_q, 1);
    check("unf_tos", dut.tos, 16'h0001);

    // Boundary: POP k == sp is legal
    clear_mem();
    mem[0] = 16'h0007; mem[1] = 16'hB001; mem[2] = 16'hE000;
    apply_reset();
    run_to_halt("popb", 100);
    check("popb_fault", fault, 0);
    check("popb_sp", dut.sp_q, 0);
`endif

    // T8: reset asserted while a fetch is pending
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 0) ? 16'h0001 : 16'hB001;
    ack_delay = 0;
    apply_reset();
    reset = 1'b1;
    n = 0;
    while (dut.pc_q < 16'd3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ack_delay = 20;
    repeat (3) @(posedge clk);
    #1;
    check("t8_req_pending", mem_req, 1);
    check("t8_pc_advanced", dut.pc_q >= 16'd3, 1);
    #2 reset = 1'b0;
    #1;
    check("t8_req_dropped", mem_req, 0);
    check("t8_pc_reset", dut.pc_q, 0);
    check("t8_addr_reset", mem_addr, 0);
    ack_delay = 0;
    apply_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
